// File: rtl/gng_noise_scaler.sv
// Scales gng Gaussian samples by sigma into rounded Torus32 error terms behind a credit-limited FIFO.
// Optional tail clamp of gng_data to +/-CLIP_BOUND is compiled in with `define GNG_NOISE_CLIP_EN.
module gng_noise_scaler #(
  parameter int FRAC       = 11,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 16,
  parameter int CLIP_BOUND = 12288
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] req_count,
  input  logic [31:0]      sigma,
  output logic             gng_ce,
  input  logic             gng_valid,
  input  logic [31:0]      gng_data,
  output logic             err_valid,
  input  logic             err_ready,
  output logic [31:0]      err_data,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | issuing gng credits until req_q have been requested
  // DRAIN | waiting for in-flight samples, pipeline and FIFO to empty
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 3;
  localparam logic signed [64:0] HALF = 65'sd1 <<< (FRAC - 1);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || FRAC < 1 || CLIP_BOUND < 1) begin : g_param_check
    $error("gng_noise_scaler: illegal parameter set");
  end

  state_t state, state_n;

  logic [CNT_W-1:0] req_q, issued, issued_n;
  logic [31:0]      sigma_q;
  logic [AW:0]      inflight, inflight_n;
  logic [AW:0]      fifo_cnt, fifo_cnt_n;
  logic [OW-1:0]    occ_n;
  logic             s1_v, s2_v;
  logic             gv_ok, pop, push_ok, fifo_full;
  logic             start_acc, ce_d, done_d, drained, ovf_set;

  logic signed [31:0] data_in;
  logic signed [64:0] mul_a, mul_b, s1_p, rnd;
  logic [31:0]        s2_e;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  assign busy      = (state != IDLE);
  assign err_valid = (fifo_cnt != '0);
  assign err_data  = err_valid ? mem[rd_ptr] : '0;
  assign fifo_full = (fifo_cnt == (AW+1)'(DEPTH));
  assign pop       = err_valid && err_ready;
  assign push_ok   = s2_v && (!fifo_full || pop);

  // A valid with no outstanding credit is a protocol error; it is flagged and dropped.
  assign gv_ok   = gng_valid && (inflight != '0);
  assign ovf_set = (gng_valid && (inflight == '0)) || (s2_v && fifo_full && !pop);

  // gng_ce is registered, so credit decisions look at next-cycle occupancy.
  assign inflight_n = inflight + (AW+1)'(gng_ce) - (AW+1)'(gv_ok);
  assign fifo_cnt_n = fifo_cnt + (AW+1)'(push_ok) - (AW+1)'(pop);
  assign issued_n   = issued + CNT_W'(gng_ce);
  assign occ_n      = OW'(fifo_cnt_n) + OW'(gv_ok) + OW'(s1_v) + OW'(inflight_n);
  assign drained    = (inflight == '0) && !s1_v && !s2_v && (fifo_cnt_n == '0);

`ifdef GNG_NOISE_CLIP_EN
  localparam logic signed [31:0] CLIP_HI = 32'(CLIP_BOUND);
  localparam logic signed [31:0] CLIP_LO = -CLIP_HI;

  always_comb begin
    data_in = $signed(gng_data);
    if ($signed(gng_data) > CLIP_HI)      data_in = CLIP_HI;
    else if ($signed(gng_data) < CLIP_LO) data_in = CLIP_LO;
  end
`else
  assign data_in = $signed(gng_data);
`endif

  assign mul_a = {{33{data_in[31]}}, data_in};
  assign mul_b = {33'd0, sigma_q};
  assign rnd   = s1_p + HALF;

  always_comb begin
    state_n   = state;
    start_acc = 1'b0;
    done_d    = 1'b0;
    ce_d      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_n   = RUN;
        end
      end
      RUN: begin
        if ((issued == req_q) && !gng_ce) state_n = DRAIN;
        ce_d = (issued_n < req_q) && (occ_n < OW'(DEPTH));
      end
      DRAIN: begin
        if (drained) begin
          done_d  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      req_q    <= '0;
      sigma_q  <= '0;
      issued   <= '0;
      inflight <= '0;
      gng_ce   <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_n;
      gng_ce   <= ce_d;
      done     <= done_d;
      inflight <= inflight_n;
      ovf      <= (ovf && !start_acc) | ovf_set;
      if (start_acc) begin
        req_q   <= req_count;
        sigma_q <= sigma;
        issued  <= '0;
      end else begin
        issued  <= issued_n;
      end
    end
  end

  // Full-width product; e keeps only bits [FRAC+31:FRAC] since the torus wraps mod 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s1_p <= '0;
      s2_e <= '0;
    end else begin
      s1_v <= gv_ok;
      s2_v <= s1_v;
      if (gv_ok) s1_p <= mul_a * mul_b;
      if (s1_v)  s2_e <= rnd[FRAC+31:FRAC];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= s2_e;
  end

endmodule

// File: doc/gng_noise_scaler.md
Name: gng_noise_scaler

Overview:
- Sits directly downstream of the gng Gaussian noise core in the TFHE CGGI key-generation datapath.
- Requests exactly N samples per job from gng via its ce input, using a credit scheme.
- Converts each 32-bit signed fixed-point sample (FRAC fractional bits) to a Torus32 LWE error term, e = round(x * sigma), and buffers the results in a FIFO.
- Delivers error terms on a ready/valid stream to the LWE key-switch / bootstrapping-key encryptor.

Parameters:
- FRAC, 11, fractional bits of gng_data (signed Q(31-FRAC).FRAC).
- DEPTH, 16, output FIFO depth in entries (power of two, at least 4).
- CNT_W, 16, width of the job sample counter.
- CLIP_BOUND, 12288, magnitude clip in gng_data LSBs (6.0 at FRAC=11); used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle job start pulse; ignored unless the FSM is in IDLE
- req_count  in  CNT_W  number of samples for the job; latched on start
- sigma  in  32  unsigned standard deviation in Torus32 units (sigma*2^32); latched on start
- gng_ce  out  1  drives gng ce
- gng_valid  in  1  gng valid_out
- gng_data  in  32  gng data_out, signed
- err_valid  out  1  FIFO non-empty
- err_ready  in  1  consumer ready
- err_data  out  32  Torus32 error term at the FIFO head
- busy  out  1  FSM not in IDLE
- done  out  1  one-cycle pulse when the job has fully drained
- ovf  out  1  sticky protocol-error flag

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: all outputs are 0. FSM is in IDLE. FIFO, counters, pipeline valids and latched registers are cleared.
- rst mid-job: the job is abandoned and no done pulse is issued. The gng core is reset separately, so no stale credit persists.
- Credit accounting:
  - inflight counts ce cycles not yet answered by gng_valid: +1 on gng_ce, -1 on gng_valid, both in the same cycle gives net 0.
  - occ = fifo_count + pipe_valid_count (0..2) + inflight.
  - gng_ce = (state==RUN) && (issued < req_q) && (occ < DEPTH). It is a registered output.
  - issued increments on every cycle that gng_ce is high.
- Datapath (signed 32 x unsigned 32, full 65-bit product, no intermediate truncation):
  - S1 (cycle after gng_valid): p = gng_data * {1'b0, sigma_q}.
  - S2: r = (p + 2^(FRAC-1)) >>> FRAC, giving round-half-up toward +inf. e = r[31:0], which wraps mod 2^32 as the torus requires.
  - S3: e is written to the FIFO.
  - With the FIFO empty, err_valid rises 3 cycles after the cycle gng_valid was sampled high.
- FIFO: the head is presented combinationally. Pop when err_valid && err_ready. Push and pop in the same cycle are allowed at any occupancy. The credit scheme guarantees no push when full.
- FSM states:
  - IDLE: on start, latch req_q=req_count and sigma_q=sigma, clear issued, clear ovf, go to RUN.
  - RUN: issue credits. When issued==req_q and gng_ce is low, go to DRAIN.
  - DRAIN: wait until inflight==0, the pipeline is empty and the FIFO is empty (last pop). Then pulse done for 1 cycle and go to IDLE.
- req_count==0: start goes through RUN to DRAIN with no gng_ce. done pulses 3 cycles after start.
- Backpressure: when err_ready is held low, gng_ce stops once occ==DEPTH. No sample is ever lost.
- ovf sets on either condition below; it is cleared only by rst or an accepted start:
  - gng_valid while inflight==0;
  - an S3 push while the FIFO is full.
- start while busy: ignored, and the latched values are unchanged.

Optional Feature:
- Macro GNG_NOISE_CLIP_EN.
- Defined: before S1, gng_data is clamped to [-CLIP_BOUND, +CLIP_BOUND] (tail-bound the noise). Latency is unchanged.
- Undefined: no clamp. gng_data feeds the multiplier directly, and CLIP_BOUND is unused.

Test Plan:
- Rounding:
  - sigma=1, gng_data=1024 -> e=0x00000001.
  - sigma=1, gng_data=-1024 -> e=0x00000000.
  - sigma=1, gng_data=-1025 -> e=0xFFFFFFFF.
  - gng_data=2048, sigma=0x00010000 -> e=0x00010000.
- Job count: start with req_count=100, err_ready=1, gng model with 5-cycle latency -> exactly 100 gng_ce cycles and 100 err pops; done pulses once after the last pop; busy drops with done; ovf=0.
- Backpressure: req_count=40, err_ready=0 for 200 cycles -> gng_ce stops with occ=16 and FIFO holds 16 entries. Then err_ready=1 -> all 40 delivered in order, matching the reference model.
- Edge cases:
  - req_count=0 -> no gng_ce; done 3 cycles after start.
  - start while busy -> ignored.
  - Spurious gng_valid in IDLE -> ovf=1 until the next start.
- Reset mid-job: assert rst at sample 20 of 50 -> next cycle all outputs 0 and FIFO empty; a new job with req_count=5 completes normally.
- Clip (GNG_NOISE_CLIP_EN defined):
  - gng_data=20000, sigma=1 -> e=6.
  - gng_data=-20000, sigma=1 -> e=0xFFFFFFFA.
  - Undefined: gng_data=20000, sigma=1 -> e=10.
